usb_tx_arbiter: RTL
===================

USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter MAX_PKT, default 64, maximum bytes per packet (1..1023).
REQ-003 SHALL have port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port req_i, input, N_REQ, per-requester packet request.
REQ-006 SHALL have port data_i, input, 8*N_REQ, per-requester byte; requester k uses bits [8k+7:8k].
REQ-007 SHALL have port valid_i, input, N_REQ, per-requester byte valid.
REQ-008 SHALL have port last_i, input, N_REQ, per-requester last byte of packet.
REQ-009 SHALL have port ready_o, output, N_REQ, per-requester byte accepted.
REQ-010 SHALL have port grant_o, output, N_REQ, one-hot current owner; all zero when not owned.
REQ-011 SHALL have port tx_data_o, output, 8, byte to the shared SIE transmit path.
REQ-012 SHALL have port tx_valid_o, output, 1, tx_data_o valid.
REQ-013 SHALL have port tx_last_o, output, 1, last byte of the current packet.
REQ-014 SHALL have port tx_ready_i, input, 1, SIE accepts the byte.
REQ-015 SHALL have port abort_i, input, 1, SIE abort (bus reset or timeout).
REQ-016 SHALL have port busy_o, output, 1, arbiter owns the transmit path.

Function
REQ-017 SHALL implement states IDLE, XFER and GAP.
REQ-018 IDLE: when any req_i bit is set, the arbiter SHALL select the first set bit at or after rr_ptr (round-robin, wrapping N_REQ-1 to 0), set grant_o one-hot and enter XFER on the next edge.
REQ-019 XFER: tx_data_o, tx_valid_o and last SHALL be combinational muxes of the granted requester's data_i, valid_i and last_i.
REQ-020 XFER: ready_o[g] SHALL equal tx_ready_i; all other ready_o bits SHALL be 0.
REQ-021 A byte transfer SHALL occur on a cycle with tx_valid_o and tx_ready_i both high.
REQ-022 An 11-bit byte counter SHALL clear on entry to XFER and increment on each transfer.
REQ-023 tx_last_o SHALL be last_i[g] OR (count == MAX_PKT-1).
REQ-024 A transfer with tx_last_o high SHALL end the packet: next state GAP; rr_ptr SHALL become (g+1) mod N_REQ.
REQ-025 A packet truncated by MAX_PKT SHALL NOT alter requester-side last_i handling; the requester's next byte starts a new packet on a later grant.
REQ-026 GAP SHALL last exactly 1 cycle with grant_o = 0, then IDLE; this gives a minimum 1 idle cycle between packets.
REQ-027 A deasserted req_i[g] during XFER SHALL NOT release the grant; only the end of packet or an abort does.
REQ-028 abort_i high in any state SHALL force GAP on the next edge, clear grant_o and advance rr_ptr past g if in XFER.
REQ-029 If abort_i is high in the same cycle as a last-byte transfer, abort SHALL win; the byte counts as sent.
REQ-030 busy_o SHALL be 1 in XFER, 0 otherwise.
REQ-031 In IDLE and GAP, tx_valid_o, tx_last_o, ready_o and grant_o SHALL be 0, and tx_data_o SHALL be 0.

Reset
REQ-032 rstn_i low SHALL immediately force IDLE, rr_ptr=0, count=0 and all outputs 0, including in mid-packet; no partial packet resumes after reset.

Verification
REQ-033 Single requester: req_i=0001 with 3 bytes A1,B2,C3 and last on C3, tx_ready_i=1 -> grant_o=0001 one cycle after req; tx_data_o A1,B2,C3 over 3 cycles; tx_last_o on C3; then GAP for 1 cycle, then IDLE.
REQ-034 Fairness: req_i=1111 held, 1-byte packets -> grants cycle in order 0001, 0010, 0100, 1000, 0001, each separated by GAP.
REQ-035 Truncation: MAX_PKT=4 and requester 2 streams 10 bytes with no last -> tx_last_o on the 4th byte; the arbiter moves to the next requester; requester 2 is served again only after its round-robin turn.
REQ-036 Backpressure: tx_ready_i toggling 1,0,1,0 -> each byte transferred once; ready_o[g] mirrors tx_ready_i; the count increments only on handshakes.
REQ-037 Abort: abort_i pulsed after 2 of 5 bytes, and abort_i coincident with a last byte -> GAP next cycle, grant_o=0 and rr_ptr advanced; the abort-with-last case takes GAP via the abort path.
REQ-038 Reset mid-packet: rstn_i low during XFER -> all outputs 0 asynchronously; after release with req_i=0100, the grant is 0100 (rr_ptr restarted at 0).

Source files
------------

// File: rtl/usb_tx_arbiter.sv
// Round-robin arbiter sharing one USB SIE transmit byte path among N_REQ requesters.
// A grant is held for a whole packet (last_i, MAX_PKT truncation or abort), then one GAP cycle.
module usb_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MAX_PKT = 64
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [8*N_REQ-1:0] data_i,
    input  logic [N_REQ-1:0]   valid_i,
    input  logic [N_REQ-1:0]   last_i,
    output logic [N_REQ-1:0]   ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_valid_o,
    output logic               tx_last_o,
    input  logic               tx_ready_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic [1:0]         state_o
);
    localparam int          IW       = $clog2(N_REQ);
    localparam logic [IW:0] N_WRAP   = (IW+1)'(N_REQ);
    localparam logic [10:0] LAST_CNT = 11'(MAX_PKT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_q, rr_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [IW-1:0] pick, gnext;
    logic [IW:0]   cand;
    logic [10:0]   count_q, count_d;
    logic          found;
    logic          xfer;

    // First requesting index at or after rr_q, wrapping N_REQ-1 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_q} + (IW+1)'(i);
            if (cand >= N_WRAP) cand = cand - N_WRAP;
            if (!found && req_i[cand[IW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IW-1:0];
            end
        end
    end

    assign gnext = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + IW'(1);

    // Handshake: a byte moves on any cycle where tx_valid_o and tx_ready_i are both high;
    // the owner sees that same tx_ready_i on its ready_o bit, all other ready_o bits stay 0.
    always_comb begin
        grant_o    = '0;
        ready_o    = '0;
        tx_data_o  = '0;
        tx_valid_o = 1'b0;
        tx_last_o  = 1'b0;
        if (state_q == XFER) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (gidx_q == IW'(k)) begin
                    grant_o[k] = 1'b1;
                    ready_o[k] = tx_ready_i;
                    tx_data_o  = data_i[8*k +: 8];
                    tx_valid_o = valid_i[k];
                    tx_last_o  = last_i[k] | (count_q == LAST_CNT);
                end
            end
        end
    end

    assign xfer    = tx_valid_o & tx_ready_i;
    assign busy_o  = (state_q == XFER);
    assign state_o = state_q;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gidx_d  = gidx_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (abort_i) begin
                    state_d = GAP;
                end else if (found) begin
                    state_d = XFER;
                    gidx_d  = pick;
                    count_d = '0;
                end
            end
            XFER: begin
                if (xfer) count_d = count_q + 11'd1;
                // Abort takes priority over a coincident last byte; both end the packet.
                if (abort_i || (xfer && tx_last_o)) begin
                    state_d = GAP;
                    rr_d    = gnext;
                end
            end
            GAP: begin
                state_d = abort_i ? GAP : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gidx_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gidx_q  <= gidx_d;
            count_q <= count_d;
        end
    end

endmodule
